// File: rtl/flag_branch_resolver.sv
// Flag register and branch resolver: latches ALU NZCV flags and returns a registered taken/not-taken decision.
// Define FLAG_BRANCH_FWD_EN to forward same-cycle ALU flags into B.cond instead of stalling one cycle.
module flag_branch_resolver #(
    parameter int COND_W = 4,
    parameter int TYPE_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_flags,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_c,
    input  logic              alu_v,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [TYPE_W-1:0] br_type,
    input  logic [COND_W-1:0] br_cond,
    input  logic              op_zero,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_taken,
    output logic [3:0]        flags_q
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FULL = 1'b1;

    localparam logic [TYPE_W-1:0] TYPE_B     = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] TYPE_BCOND = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] TYPE_CBZ   = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] TYPE_CBNZ  = TYPE_W'(3);

    logic [0:0] state_q;
    logic [0:0] state_d;
    logic       outTaken_q;
    logic       outTaken_d;
    logic [3:0] flags_d;
    logic [3:0] aluFlags;
    logic [3:0] evalFlags;
    logic       condStall;
    logic       accept;
    logic       evalTaken;

    // Flags are packed {N,Z,C,V}; bit 3 is N, bit 0 is V.
    function automatic logic condPass(input logic [3:0] cond, input logic [3:0] f);
        logic n;
        logic z;
        logic c;
        logic v;
        logic pass;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'h0:    pass = z;
            4'h1:    pass = !z;
            4'h2:    pass = c;
            4'h3:    pass = !c;
            4'h4:    pass = n;
            4'h5:    pass = !n;
            4'h6:    pass = v;
            4'h7:    pass = !v;
            4'h8:    pass = c && !z;
            4'h9:    pass = !c || z;
            4'hA:    pass = (n == v);
            4'hB:    pass = (n != v);
            4'hC:    pass = !z && (n == v);
            4'hD:    pass = z || (n != v);
            default: pass = 1'b1;
        endcase
        return pass;
    endfunction

    assign aluFlags  = {alu_n, alu_z, alu_c, alu_v};
    assign out_valid = (state_q == FULL);
    assign out_taken = outTaken_q;

`ifdef FLAG_BRANCH_FWD_EN
    assign condStall = 1'b0;
    assign evalFlags = set_flags ? aluFlags : flags_q;
`else
    // A B.cond arriving with a flag write waits one cycle so it sees the new flags_q.
    assign condStall = br_valid && (br_type == TYPE_BCOND) && set_flags;
    assign evalFlags = flags_q;
`endif

    assign br_ready = (!out_valid || out_ready) && !condStall;
    assign accept   = br_valid && br_ready && !flush;

    always_comb begin
        evalTaken = 1'b1;
        case (br_type)
            TYPE_B:     evalTaken = 1'b1;
            TYPE_BCOND: evalTaken = condPass(4'(br_cond), evalFlags);
            TYPE_CBZ:   evalTaken = op_zero;
            TYPE_CBNZ:  evalTaken = !op_zero;
            default:    evalTaken = 1'b1;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if (set_flags) begin
            flags_d = aluFlags;
        end
    end

    // Flush wins over everything; a same-cycle consume and accept keeps the slot full with new data.
    always_comb begin
        state_d    = state_q;
        outTaken_d = outTaken_q;
        if (flush) begin
            state_d    = IDLE;
            outTaken_d = 1'b0;
        end else if (accept) begin
            state_d    = FULL;
            outTaken_d = evalTaken;
        end else if (out_valid && out_ready) begin
            state_d    = IDLE;
            outTaken_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            outTaken_q <= 1'b0;
            flags_q    <= 4'b0000;
        end else begin
            state_q    <= state_d;
            outTaken_q <= outTaken_d;
            flags_q    <= flags_d;
        end
    end

endmodule

// File: doc/flag_branch_resolver.md
Name: flag_branch_resolver

Overview:
- Consumer end of the ALU zero/flag path: latches NZCV flags from flag-setting ALU ops.
- Evaluates branch requests (B, B.cond, CBZ, CBNZ) against the latched flags or the operand-zero bit.
- Returns a registered taken/not-taken decision to the fetch/PC logic over a valid/ready handshake.
- Sits between the EX stage (flags, zero check) and the PC-select mux.

Parameters:
- COND_W, 4, width of condition-code field (ARMv8 encoding)
- TYPE_W, 2, width of branch-type field

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- set_flags  input  1  ALU op this cycle writes flags
- alu_n  input  1  negative flag from ALU
- alu_z  input  1  zero flag from ALU (zero_check output)
- alu_c  input  1  carry flag from ALU
- alu_v  input  1  overflow flag from ALU
- br_valid  input  1  branch request present
- br_ready  output  1  resolver can accept request this cycle
- br_type  input  TYPE_W  0=B, 1=B.cond, 2=CBZ, 3=CBNZ
- br_cond  input  COND_W  condition code for B.cond
- op_zero  input  1  operand register is zero (CBZ/CBNZ)
- flush  input  1  synchronous kill of pending decision
- out_valid  output  1  decision available
- out_ready  input  1  PC logic consumes decision
- out_taken  output  1  branch taken
- flags_q  output  4  architectural {N,Z,C,V}

Behaviour:
- Reset (rst_n=0, async): flags_q=4'b0000, out_valid=0, out_taken=0, internal state IDLE; br_ready=1 after reset release.
- Flag register: on posedge clk with set_flags=1, flags_q <= {alu_n,alu_z,alu_c,alu_v}; otherwise hold. Flag update is independent of branch handshake and of flush.
- Handshake: request accepted when br_valid && br_ready. br_ready = !out_valid || out_ready (combinational; single-entry output register).
- Latency: accepted request -> out_valid=1 on the next rising edge, out_taken set from evaluation.
- Output hold: while out_valid && !out_ready, out_valid/out_taken hold stable; br_ready=0.
- Simultaneous consume and accept (out_valid && out_ready && br_valid): new decision replaces old in the same edge, out_valid stays 1.
- Consume without new accept: out_valid -> 0.
- States:
  - IDLE (out_valid=0): accept -> FULL.
  - FULL (out_valid=1): out_ready && !accept -> IDLE; out_ready && accept -> FULL with new data.
  - flush=1 -> IDLE from either state; any same-cycle request is dropped.
- Evaluation by br_type:
  - B: taken=1.
  - CBZ: taken=op_zero.
  - CBNZ: taken=!op_zero.
  - B.cond: taken from flags F (see below) per br_cond:
    - 0 EQ: Z; 1 NE: !Z
    - 2 CS: C; 3 CC: !C
    - 4 MI: N; 5 PL: !N
    - 6 VS: V; 7 VC: !V
    - 8 HI: C&!Z; 9 LS: !C|Z
    - A GE: N==V; B LT: N!=V
    - C GT: !Z&(N==V); D LE: Z|(N!=V)
    - E, F: 1
- F = flags_q unless overridden (see Optional Feature). CBZ/CBNZ/B ignore flags entirely.
- Reset mid-operation: pending decision discarded, flags cleared, no out_valid glitch after release.

Optional Feature:
- Macro FLAG_BRANCH_FWD_EN.
- Defined: same-cycle forwarding. When set_flags=1 and a B.cond is accepted in the same cycle, F = {alu_n,alu_z,alu_c,alu_v}; no stall.
- Undefined: no forwarding. When br_valid && br_type==1 && set_flags, br_ready is forced 0 for that cycle; the request is accepted the following cycle using the updated flags_q. This adds one bubble.
- B/CBZ/CBNZ never stall in either build.

Test Plan:
- Reset: assert rst_n=0 mid-FULL with flags_q=4'b1111 -> out_valid=0 and flags_q=0 immediately (async); br_ready=1 after release.
- Flag latch + EQ/NE: set_flags with alu_z=1, next cycle B.cond cond=0 -> out_taken=1 one cycle later; cond=1 -> out_taken=0.
- Signed conds: flags N=1,V=0 -> LT(B) taken=1, GE(A) taken=0, GT(C) taken=0, LE(D) taken=1; N=1,V=1,Z=0 -> GT taken=1.
- CBZ/CBNZ: op_zero=1 with CBZ -> taken=1; op_zero=0 with CBNZ -> taken=1; flags_q changes have no effect.
- Backpressure: out_ready=0 for 3 cycles with br_valid held -> br_ready=0, out_taken stable. Then out_ready=1 with a new request -> back-to-back accept, out_valid stays 1.
- Same-cycle flags + B.cond EQ, alu_z=1, flags_q.Z=0:
  - FLAG_BRANCH_FWD_EN defined -> taken=1 at +1 cycle.
  - Undefined -> br_ready=0 one cycle, taken=1 at +2 cycles.
  - Flush in FULL -> out_valid=0 next edge.
